// File: rtl/ulpb_rx_deframer.sv
// rtl/ulpb_rx_deframer.sv - bus receive deframer with address filter and payload FIFO
module ulpb_rx_deframer #(
  parameter logic [7:0] NODE_ADDR   = 8'h5A,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         IDLE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BUS_CLK,
  input  logic       BUS_DIN,
  output logic [7:0] RX_DATA,
  output logic       RX_LAST,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       ADDR_MATCH,
  output logic       OVERFLOW,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, DROP} state_t;

  state_t        state;
  logic [2:0]    bclk_sync;
  logic [2:0]    din_sync;
  logic          armed;
  logic [IW-1:0] idle_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic [7:0]    stage_q;
  logic          stage_full;
  logic          addr_match_q;
  logic          frame_err_q;
  logic          busy_q;
  logic          overflow_q;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          bclk_s;
  logic          din_s;
  logic          rise;
  logic          start_cond;
  logic          frame_end;
  logic [7:0]    new_byte;
  logic          push_en;
  logic          push_last;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;

  assign bclk_s     = bclk_sync[1];
  assign din_s      = din_sync[1];
  assign rise       = bclk_sync[1] & ~bclk_sync[2];
  // armed blocks a false start until both lines have been seen idle-high
  assign start_cond = armed & bclk_s & din_sync[2] & ~din_sync[1];
  assign frame_end  = (state != IDLE) && bclk_s && (idle_cnt == IW'(IDLE_CYCLES - 1));
  assign new_byte   = {shift_q[6:0], din_s};

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop        = RX_VALID & RX_READY;
  assign push_ok    = push_en & (~fifo_full | pop);

  assign RX_VALID   = (count != '0);
  assign RX_DATA    = RX_VALID ? mem[rd_ptr][7:0] : 8'h00;
  assign RX_LAST    = RX_VALID ? mem[rd_ptr][8]   : 1'b0;
  assign ADDR_MATCH = addr_match_q;
  assign OVERFLOW   = overflow_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = busy_q;

  // Two-flop synchronisers plus a history flop for edge detection; preset high
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bclk_sync <= 3'b111;
      din_sync  <= 3'b111;
    end else begin
      bclk_sync <= {bclk_sync[1:0], BUS_CLK};
      din_sync  <= {din_sync[1:0], BUS_DIN};
    end
  end

  // Staged byte is pushed when the next byte completes (LAST=0) or at frame end (LAST=1)
  always_comb begin
    push_en   = 1'b0;
    push_last = 1'b0;
    if (state == DATA) begin
      if (frame_end) begin
        push_en   = stage_full;
        push_last = 1'b1;
      end else if (rise && bit_cnt == 3'd7) begin
        push_en   = stage_full;
      end
    end
  end

  // Frame FSM: start detect, arbitration skip, address match, payload deframing
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state        <= IDLE;
      busy_q       <= 1'b0;
      armed        <= 1'b0;
      idle_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      stage_q      <= '0;
      stage_full   <= 1'b0;
      addr_match_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (state == IDLE || !bclk_s) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (state == IDLE) begin
        if (bclk_s && din_s) begin
          armed <= 1'b1;
        end
        if (start_cond) begin
          state      <= ARB;
          busy_q     <= 1'b1;
          armed      <= 1'b0;
          bit_cnt    <= '0;
          shift_q    <= '0;
          stage_q    <= '0;
          stage_full <= 1'b0;
        end
      end else if (frame_end) begin
        state        <= IDLE;
        busy_q       <= 1'b0;
        addr_match_q <= 1'b0;
        stage_full   <= 1'b0;
        if (state == DATA && bit_cnt != 3'd0) begin
          frame_err_q <= 1'b1;
        end
      end else if (rise) begin
        if (state == ARB) begin
          state   <= ADDR;
          bit_cnt <= '0;
        end else if (state == ADDR) begin
          shift_q <= new_byte;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            if (new_byte == NODE_ADDR || new_byte == 8'hFF) begin
              state        <= DATA;
              addr_match_q <= 1'b1;
            end else begin
              state <= DROP;
            end
          end
        end else if (state == DATA) begin
          shift_q <= new_byte;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            stage_q    <= new_byte;
            stage_full <= 1'b1;
          end
        end
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow (cleared by the next frame start)
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == IDLE && start_cond) begin
        overflow_q <= 1'b0;
      end else if (push_en && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates the outputs
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= {push_last, stage_q};
    end
  end

endmodule

// File: tb/tb_ulpb_rx_deframer.sv
// tb/tb_ulpb_rx_deframer.sv - directed self-checking bench for ulpb_rx_deframer
module tb_ulpb_rx_deframer;

  logic       CLK;
  logic       RESET;
  logic       BUS_CLK;
  logic       BUS_DIN;
  logic [7:0] RX_DATA;
  logic       RX_LAST;
  logic       RX_VALID;
  logic       RX_READY;
  logic       ADDR_MATCH;
  logic       OVERFLOW;
  logic       FRAME_ERR;
  logic       BUSY;

  int total = 0;
  int bad   = 0;
  int ferr_hi = 0;

  ulpb_rx_deframer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BUS_CLK    (BUS_CLK),
    .BUS_DIN    (BUS_DIN),
    .RX_DATA    (RX_DATA),
    .RX_LAST    (RX_LAST),
    .RX_VALID   (RX_VALID),
    .RX_READY   (RX_READY),
    .ADDR_MATCH (ADDR_MATCH),
    .OVERFLOW   (OVERFLOW),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // count every cycle FRAME_ERR is seen high
  always @(negedge CLK) begin
    if (FRAME_ERR) ferr_hi++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    BUS_CLK = 1'b0;
    BUS_DIN = b;
    wait_cycles(4);
    BUS_CLK = 1'b1;
    wait_cycles(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic start_frame(input logic [7:0] addr);
    BUS_CLK = 1'b1;
    BUS_DIN = 1'b1;
    wait_cycles(4);
    BUS_DIN = 1'b0;
    wait_cycles(4);
    send_bit(1'b1);
    send_byte(addr);
  endtask

  task automatic end_frame();
    BUS_CLK = 1'b1;
    BUS_DIN = 1'b1;
    wait_cycles(30);
  endtask

  task automatic pop_one(output logic ok, output logic [7:0] d, output logic l);
    ok = 1'b0;
    d  = 8'h00;
    l  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (RX_VALID) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (ok) begin
      d = RX_DATA;
      l = RX_LAST;
      RX_READY = 1'b1;
      @(negedge CLK);
      RX_READY = 1'b0;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    wait_cycles(2);
    RESET = 1'b1;
    BUS_CLK = 1'b1;
    BUS_DIN = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    BUS_CLK = 1'b1;
    BUS_DIN = 1'b1;
    RX_READY = 1'b0;
    wait_cycles(2);
    total++;
    if ({RX_DATA, RX_LAST, RX_VALID, ADDR_MATCH, OVERFLOW, FRAME_ERR, BUSY} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h %b%b%b%b%b%b want all zero", RX_DATA, RX_LAST, RX_VALID, ADDR_MATCH, OVERFLOW, FRAME_ERR, BUSY);
    end
    RESET = 1'b1;
    wait_cycles(20);
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_no_start: BUSY=%b want 0", BUSY); end
  endtask

  task automatic test_basic();
    logic ok; logic [7:0] d; logic l;
    ferr_hi = 0;
    start_frame(8'h5A);
    send_byte(8'h12);
    total++;
    if (ADDR_MATCH !== 1'b1) begin bad++; $display("FAIL basic_addr_match: got %b want 1", ADDR_MATCH); end
    send_byte(8'h34);
    end_frame();
    total++;
    if (ADDR_MATCH !== 1'b0) begin bad++; $display("FAIL basic_match_clear: got %b want 0", ADDR_MATCH); end
    pop_one(ok, d, l);
    total++;
    if (!ok || d !== 8'h12 || l !== 1'b0) begin bad++; $display("FAIL basic_byte0: ok=%b got %h/%b want 12/0", ok, d, l); end
    pop_one(ok, d, l);
    total++;
    if (!ok || d !== 8'h34 || l !== 1'b1) begin bad++; $display("FAIL basic_byte1: ok=%b got %h/%b want 34/1", ok, d, l); end
    total++;
    if (ferr_hi !== 0) begin bad++; $display("FAIL basic_frame_err: got %0d want 0", ferr_hi); end
  endtask

  task automatic test_addr_filter();
    logic ok; logic [7:0] d; logic l;
    start_frame(8'h33);
    send_byte(8'hAB);
    total++;
    if (BUSY !== 1'b1 || ADDR_MATCH !== 1'b0) begin bad++; $display("FAIL filter_busy: BUSY=%b AM=%b want 1/0", BUSY, ADDR_MATCH); end
    end_frame();
    total++;
    if (RX_VALID !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL filter_empty: VALID=%b BUSY=%b want 0/0", RX_VALID, BUSY); end
    start_frame(8'hFF);
    send_byte(8'hAB);
    end_frame();
    pop_one(ok, d, l);
    total++;
    if (!ok || d !== 8'hAB || l !== 1'b1) begin bad++; $display("FAIL broadcast_byte: ok=%b got %h/%b want AB/1", ok, d, l); end
  endtask

  task automatic test_overflow();
    logic ok; logic [7:0] d; logic l;
    start_frame(8'h5A);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    end_frame();
    total++;
    if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", OVERFLOW); end
    for (int i = 1; i <= 4; i++) begin
      pop_one(ok, d, l);
      total++;
      if (!ok || d !== 8'(i) || l !== 1'b0) begin bad++; $display("FAIL ovf_byte%0d: ok=%b got %h/%b want %h/0", i, ok, d, l, 8'(i)); end
    end
    wait_cycles(2);
    total++;
    if (RX_VALID !== 1'b0) begin bad++; $display("FAIL ovf_drained: VALID=%b want 0", RX_VALID); end
    BUS_DIN = 1'b0;
    wait_cycles(6);
    total++;
    if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", OVERFLOW); end
    end_frame();
  endtask

  task automatic test_frame_err();
    logic ok; logic [7:0] d; logic l;
    ferr_hi = 0;
    start_frame(8'h5A);
    send_byte(8'hC3);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    end_frame();
    total++;
    if (ferr_hi !== 1) begin bad++; $display("FAIL ferr_pulse: high cycles %0d want 1", ferr_hi); end
    pop_one(ok, d, l);
    total++;
    if (!ok || d !== 8'hC3 || l !== 1'b1) begin bad++; $display("FAIL ferr_byte: ok=%b got %h/%b want C3/1", ok, d, l); end
    wait_cycles(2);
    total++;
    if (RX_VALID !== 1'b0) begin bad++; $display("FAIL ferr_no_partial: VALID=%b want 0", RX_VALID); end
  endtask

  task automatic test_mid_reset();
    logic ok; logic [7:0] d; logic l;
    start_frame(8'h5A);
    send_byte(8'h99);
    end_frame();
    start_frame(8'h5A);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    BUS_CLK = 1'b0;
    BUS_DIN = 1'b1;
    wait_cycles(2);
    do_reset();
    total++;
    if (RX_VALID !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL midreset_flush: VALID=%b BUSY=%b want 0/0", RX_VALID, BUSY); end
    start_frame(8'h5A);
    send_byte(8'h77);
    end_frame();
    pop_one(ok, d, l);
    total++;
    if (!ok || d !== 8'h77 || l !== 1'b1) begin bad++; $display("FAIL midreset_byte: ok=%b got %h/%b want 77/1", ok, d, l); end
    wait_cycles(2);
    total++;
    if (RX_VALID !== 1'b0) begin bad++; $display("FAIL midreset_empty: VALID=%b want 0", RX_VALID); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_filter();
    test_overflow();
    test_frame_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
